// File: rtl/bp_mem_arbiter_pkg.sv
// Shared types and helpers for the bp_mem_arbiter slice.
package bp_mem_arbiter_pkg;

  typedef enum logic {e_arb_idle, e_arb_locked} bp_mem_arb_state_e;

  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bp_mem_arbiter_tagfifo.sv
// In-order requester-id FIFO; one push and one pop per cycle.
module bp_mem_arbiter_tagfifo
  import bp_mem_arbiter_pkg::*;
#(
  parameter int width_p = 1,
  parameter int els_p   = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  input  logic               yumi_i,
  output logic [width_p-1:0] data_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int ptr_w = safe_clog2(els_p);

  logic [width_p-1:0] mem_q [els_p];
  logic [ptr_w-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ptr_w:0]     cnt_q, cnt_d;

  always_comb begin
    wr_ptr_d = v_i    ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = yumi_i ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q + (ptr_w+1)'(v_i) - (ptr_w+1)'(yumi_i);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // storage carries no reset; occupancy is tracked by cnt_q alone
  always_ff @(posedge clk_i) begin
    if (v_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (cnt_q == (ptr_w+1)'(els_p));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/bp_mem_arbiter.sv
// Locking round-robin arbiter sharing one memory port among requesters; responses return in issue order.
// Optional perf counters when BP_MEM_ARBITER_PERF_EN is defined.
module bp_mem_arbiter
  import bp_mem_arbiter_pkg::*;
#(
  parameter int num_req_p         = 2,
  parameter int mem_msg_width_p   = 512,
  parameter int max_outstanding_p = 8
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic [num_req_p*mem_msg_width_p-1:0] cmd_i,
  input  logic [num_req_p-1:0]                 cmd_v_i,
  output logic [num_req_p-1:0]                 cmd_yumi_o,
  output logic [mem_msg_width_p-1:0]           resp_o,
  output logic [num_req_p-1:0]                 resp_v_o,
  input  logic [num_req_p-1:0]                 resp_yumi_i,
  output logic [mem_msg_width_p-1:0]           mem_cmd_o,
  output logic                                 mem_cmd_v_o,
  input  logic                                 mem_cmd_yumi_i,
  input  logic [mem_msg_width_p-1:0]           mem_resp_i,
  input  logic                                 mem_resp_v_i,
  output logic                                 mem_resp_yumi_o
);

  localparam int req_id_width = safe_clog2(num_req_p);

  bp_mem_arb_state_e       state_q, state_d;
  logic [req_id_width-1:0] locked_id_q, locked_id_d;
  logic [req_id_width-1:0] ptr_q, ptr_d;
  logic                    rst_q;
  logic                    block;

  logic [num_req_p-1:0]    eligible;
  logic                    rr_found;
  logic [req_id_width-1:0] rr_id;
  logic                    gnt_v;
  logic [req_id_width-1:0] gnt_id;
  logic                    accept;

  logic                    tag_full, tag_empty, tag_pop;
  logic [req_id_width-1:0] tag_head;

  // outputs stay quiet during reset and for one cycle after it
  assign block    = reset_i | rst_q;
  assign eligible = cmd_v_i & {num_req_p{~tag_full}};

  always_comb begin
    int idx;
    idx      = 0;
    rr_found = 1'b0;
    rr_id    = '0;
    for (int k = 0; k < num_req_p; k++) begin
      idx = (int'(ptr_q) + k) % num_req_p;
      if (!rr_found && eligible[idx]) begin
        rr_found = 1'b1;
        rr_id    = req_id_width'(idx);
      end
    end
  end

  always_comb begin
    if (state_q == e_arb_locked) begin
      gnt_id = locked_id_q;
      gnt_v  = cmd_v_i[locked_id_q];
    end else begin
      gnt_id = rr_id;
      gnt_v  = rr_found;
    end
    gnt_v = gnt_v & ~block;
  end

  assign accept = gnt_v & mem_cmd_yumi_i;

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= e_arb_idle;
      locked_id_q <= '0;
    end else begin
      state_q     <= state_d;
      locked_id_q <= locked_id_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d     = state_q;
    locked_id_d = locked_id_q;
    case (state_q)
      e_arb_idle: if (gnt_v && !mem_cmd_yumi_i) begin
        state_d     = e_arb_locked;
        locked_id_d = gnt_id;
      end
      e_arb_locked: if (mem_cmd_yumi_i) state_d = e_arb_idle;
      default: state_d = e_arb_idle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    mem_cmd_v_o = gnt_v;
    mem_cmd_o   = cmd_i[gnt_id*mem_msg_width_p +: mem_msg_width_p];
    cmd_yumi_o  = accept ? (num_req_p'(1) << gnt_id) : '0;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = (int'(gnt_id) == num_req_p-1) ? '0 : gnt_id + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q <= '0;
      rst_q <= 1'b1;
    end else begin
      ptr_q <= ptr_d;
      rst_q <= 1'b0;
    end
  end

  bp_mem_arbiter_tagfifo #(
    .width_p(req_id_width),
    .els_p  (max_outstanding_p)
  ) tags (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .data_i (gnt_id),
    .v_i    (accept),
    .yumi_i (tag_pop),
    .data_o (tag_head),
    .full_o (tag_full),
    .empty_o(tag_empty)
  );

  assign tag_pop         = mem_resp_v_i & ~tag_empty & ~block & resp_yumi_i[tag_head];
  assign mem_resp_yumi_o = tag_pop;
  assign resp_o          = mem_resp_i;
  assign resp_v_o        = (mem_resp_v_i & ~tag_empty & ~block) ? (num_req_p'(1) << tag_head) : '0;

  a_unexpected_resp: assert property (@(posedge clk_i) disable iff (reset_i)
    !(mem_resp_v_i && tag_empty));
  a_locked_drop: assert property (@(posedge clk_i) disable iff (reset_i)
    !(state_q == e_arb_locked && !cmd_v_i[locked_id_q]));

`ifdef BP_MEM_ARBITER_PERF_EN
  logic [num_req_p-1:0][31:0] acc_cnt_q, stall_cnt_q;
  logic [31:0]                full_cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_cnt_q   <= '0;
      stall_cnt_q <= '0;
      full_cnt_q  <= '0;
    end else begin
      for (int r = 0; r < num_req_p; r++) begin
        if (cmd_yumi_o[r] && ~&acc_cnt_q[r]) acc_cnt_q[r] <= acc_cnt_q[r] + 1'b1;
        if (cmd_v_i[r] && !cmd_yumi_o[r] && ~&stall_cnt_q[r]) stall_cnt_q[r] <= stall_cnt_q[r] + 1'b1;
      end
      if (tag_full && ~&full_cnt_q) full_cnt_q <= full_cnt_q + 1'b1;
    end
  end

  final begin
    for (int r = 0; r < num_req_p; r++)
      $display("bp_mem_arbiter req%0d accepted=%0d stalled=%0d", r, acc_cnt_q[r], stall_cnt_q[r]);
    $display("bp_mem_arbiter tag_full_cycles=%0d", full_cnt_q);
  end
`endif

endmodule
